// File: rtl/alu32.sv
// alu32: registered 32-bit, 8-function ALU with carry-in and NZCV status flags.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       stat
);
  logic [WIDTH-1:0] out_d, out_q, b_x;
  logic [WIDTH:0]   sum;
  logic [3:0]       stat_d, stat_q;
  logic [4:0]       sh;
  logic             c_d, v_d;
  assign sh  = b[4:0];
  assign b_x = sel[0] ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
  always_comb begin
    out_d = sum[WIDTH-1:0];
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (sel)
      3'b000, 3'b001: begin
        c_d = sum[WIDTH];
        v_d = (a[WIDTH-1] ^ b_x[WIDTH-1] ^ 1'b1) & (sum[WIDTH-1] ^ a[WIDTH-1]);
      end
      3'b010: out_d = a & b;
      3'b011: out_d = a | b;
      3'b100: out_d = a ^ b;
      3'b101: out_d = ~(a | b);
      3'b110: begin
        out_d = a << sh;
        c_d   = (sh != 5'd0) & a[5'd0 - sh];
      end
      default: begin
        out_d = $signed(a) >>> sh;
        c_d   = (sh != 5'd0) & a[sh - 5'd1];
      end
    endcase
    stat_d = {out_d[WIDTH-1], out_d == '0, c_d, v_d};
  end
  always_ff @(posedge clk) begin
    out_q  <= rst ? '0 : out_d;
    stat_q <= rst ? 4'b0000 : stat_d;
  end
  assign out  = out_q;
  assign stat = stat_q;
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: scoreboard bench for alu32 with directed vectors and a randomized op sweep.
module tb_alu32;
  logic        clk = 1'b0, rst = 1'b1, cin = 1'b0;
  logic [31:0] a = '0, b = '0, out;
  logic [2:0]  sel = '0;
  logic [3:0]  stat;
  logic [35:0] sbq[$];
  string       tq[$];
  int          n_chk = 0, n_err = 0;

  alu32 dut (.clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .cin(cin), .out(out), .stat(stat));

  always #5 clk = ~clk;

  function automatic logic [35:0] model(input logic [31:0] x, y, input logic [2:0] s, input logic c);
    logic [63:0] t;
    logic [31:0] r;
    logic        co, v;
    co = 1'b0;
    v  = 1'b0;
    case (s)
      3'd0: begin
        t = {32'd0, x} + {32'd0, y} + {63'd0, c};
        r = t[31:0]; co = t[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'd1: begin
        t = {32'd0, x} + {32'd0, ~y} + {63'd0, c};
        r = t[31:0]; co = t[32];
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = ~(x | y);
      3'd6: begin
        t = {32'd0, x} << y[4:0];
        r = t[31:0]; co = t[32];
      end
      default: begin
        t = {x, 32'd0} >> y[4:0];
        r = t[63:32] | ((y[4:0] != 0 && x[31]) ? ~(32'hFFFF_FFFF >> y[4:0]) : 32'd0);
        co = t[31];
      end
    endcase
    return {r, r[31], r == 32'd0, co, v};
  endfunction

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got out=%h stat=%b, expected out=%h stat=%b", tag, got[35:4], got[3:0], exp[35:4], exp[3:0]);
    end
  endtask

  task automatic pop_check();
    string       t;
    logic [35:0] e;
    if (sbq.size() != 0) begin
      t = tq.pop_front();
      e = sbq.pop_front();
      check(t, {out, stat}, e);
    end
  endtask

  task automatic apply(input string tag, input logic r, input logic [31:0] x, y,
                       input logic [2:0] s, input logic c, input logic [35:0] e);
    @(negedge clk);
    pop_check();
    rst = r; a = x; b = y; sel = s; cin = c;
    sbq.push_back(e);
    tq.push_back(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    apply("rst0", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, 36'h0);
    apply("rst1", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, 36'h0);
    apply("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, {32'h0000_0000, 4'b0110});
    apply("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, {32'h8000_0000, 4'b1001});
    apply("sub", 1'b0, 32'h3333_3333, 32'h5555_5555, 3'd1, 1'b1, {32'hDDDD_DDDE, 4'b1000});
    apply("and", 1'b0, 32'h8DDC_4E0E, 32'h8803_F01D, 3'd2, 1'b1, {32'h8800_400C, 4'b1000});
    apply("or", 1'b0, 32'h8DDC_4E0E, 32'h8803_F01D, 3'd3, 1'b1, model(32'h8DDC_4E0E, 32'h8803_F01D, 3'd3, 1'b1));
    apply("xor", 1'b0, 32'h8DDC_4E0E, 32'h8803_F01D, 3'd4, 1'b0, model(32'h8DDC_4E0E, 32'h8803_F01D, 3'd4, 1'b0));
    apply("nor", 1'b0, 32'h8DDC_4E0E, 32'h8803_F01D, 3'd5, 1'b0, model(32'h8DDC_4E0E, 32'h8803_F01D, 3'd5, 1'b0));
    apply("sll", 1'b0, 32'hF800_001F, 32'd3, 3'd6, 1'b0, {32'hC000_00F8, 4'b1010});
    apply("sra", 1'b0, 32'hF800_001F, 32'd3, 3'd7, 1'b0, {32'hFF00_0003, 4'b1010});
    apply("sll0", 1'b0, 32'h8000_0001, 32'hFFFF_FFE0, 3'd6, 1'b1, {32'h8000_0001, 4'b1000});
    apply("sra0", 1'b0, 32'h8000_0001, 32'h0000_0020, 3'd7, 1'b1, {32'h8000_0001, 4'b1000});
    apply("sra31", 1'b0, 32'h4000_0000, 32'd31, 3'd7, 1'b0, {32'h0000_0000, 4'b0110});
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ~ra : $urandom;
      if (i == 21)
        apply("sweep_rst", 1'b1, ra, rb, 3'(i), i[0], 36'h0);
      else
        apply($sformatf("sweep%0d_sel%0d", i, i % 8), 1'b0, ra, rb, 3'(i), i[0], model(ra, rb, 3'(i), i[0]));
    end
    @(negedge clk);
    pop_check();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
